// File: rtl/pac_drawer_if.sv
// Bus between the Pacman position/shape controller and the sprite drawer,
// plus the drawer's pixel-write port toward the VGA adapter.
interface pac_drawer_if #(parameter int TILE = 5);
  // go is a request that is accepted only while busy is low; requests seen
  // while busy are dropped. plot qualifies vga_x/vga_y/vga_colour each cycle.
  // done pulses for one cycle when the redraw finishes.
  logic                   go;
  logic [7:0]             x_in;
  logic [6:0]             y_in;
  logic [TILE*TILE-1:0]   shape;
  logic [2:0]             colour_in;
  logic [7:0]             vga_x;
  logic [6:0]             vga_y;
  logic [2:0]             vga_colour;
  logic                   plot;
  logic                   busy;
  logic                   done;
  logic [1:0]             dbg_state;

  modport slave (
    input  go, x_in, y_in, shape, colour_in,
    output vga_x, vga_y, vga_colour, plot, busy, done, dbg_state
  );

  modport master (
    output go, x_in, y_in, shape, colour_in,
    input  vga_x, vga_y, vga_colour, plot, busy, done, dbg_state
  );
endinterface

// File: rtl/pac_drawer.sv
// Pacman sprite drawer: erases the previously drawn tile, then plots the
// latched sprite, one VGA pixel write per cycle.
module pac_drawer #(
  parameter int TILE = 5
) (
  input  logic          clock,
  input  logic          reset,
  pac_drawer_if.slave   bus
);

  localparam int         CW = $clog2(TILE);
  localparam int         SW = $clog2(TILE * TILE);
  localparam logic [7:0] TX = 8'(TILE);
  localparam logic [6:0] TY = 7'(TILE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_row;
  logic [CW-1:0]          r_col;
  logic [7:0]             r_nx;
  logic [6:0]             r_ny;
  logic [TILE*TILE-1:0]   r_nshape;
  logic [2:0]             r_ncolour;
  logic [7:0]             r_ox;
  logic [6:0]             r_oy;

  logic                   w_go;
  logic                   w_last;
  logic                   w_scan;
  logic [SW-1:0]          w_idx;
  logic [7:0]             w_old_x;
  logic [6:0]             w_old_y;
  logic [7:0]             w_new_x;
  logic [6:0]             w_new_y;

  logic [7:0]             w_vga_x;
  logic [6:0]             w_vga_y;
  logic [2:0]             w_vga_colour;
  logic                   w_plot;
  logic                   w_done;

  assign w_go   = (r_state == S_IDLE) && bus.go;
  assign w_scan = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_last = (r_row == CW'(TILE - 1)) && (r_col == CW'(TILE - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.go) w_next = S_ERASE;
      S_ERASE: if (w_last) w_next = S_DRAW;
      S_DRAW:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Row-major scan counters, request latches and the remembered tile.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_row     <= '0;
      r_col     <= '0;
      r_nx      <= '0;
      r_ny      <= '0;
      r_nshape  <= '0;
      r_ncolour <= '0;
      r_ox      <= '0;
      r_oy      <= '0;
    end else begin
      if (w_go) begin
        r_nx      <= bus.x_in;
        r_ny      <= bus.y_in;
        r_nshape  <= bus.shape;
        r_ncolour <= bus.colour_in;
        r_row     <= '0;
        r_col     <= '0;
      end else if (w_scan) begin
        if (w_last) begin
          r_row <= '0;
          r_col <= '0;
        end else if (r_col == CW'(TILE - 1)) begin
          r_col <= '0;
          r_row <= r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if ((r_state == S_DRAW) && w_last) begin
        r_ox <= r_nx;
        r_oy <= r_ny;
      end
    end
  end

  assign w_idx   = SW'(r_row) * SW'(TILE) + SW'(r_col);
  assign w_old_x = r_ox * TX + 8'(r_col);
  assign w_old_y = r_oy * TY + 7'(r_row);
  assign w_new_x = r_nx * TX + 8'(r_col);
  assign w_new_y = r_ny * TY + 7'(r_row);

  always_comb begin
    w_vga_x      = '0;
    w_vga_y      = '0;
    w_vga_colour = '0;
    w_plot       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_ERASE: begin
        w_plot  = 1'b1;
        w_vga_x = w_old_x;
        w_vga_y = w_old_y;
      end
      S_DRAW: begin
        w_plot       = 1'b1;
        w_vga_x      = w_new_x;
        w_vga_y      = w_new_y;
        w_vga_colour = r_nshape[w_idx] ? r_ncolour : 3'b000;
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.vga_x      = w_vga_x;
  assign bus.vga_y      = w_vga_y;
  assign bus.vga_colour = w_vga_colour;
  assign bus.plot       = w_plot;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = w_done;
  assign bus.dbg_state  = r_state;

endmodule
